// File: rtl/apb_bridge_fsm_if.sv
// apb_bridge_fsm_if: AHB-side request/response and APB-side bus signals of the bridge
interface apb_bridge_fsm_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic               valid;
  logic               Hwrite;
  logic [ADDR_W-1:0]  Haddr;
  logic [DATA_W-1:0]  Hwdata;
  logic [NUM_SLV-1:0] Hselx;
  logic [DATA_W-1:0]  Hrdata;
  logic               Hreadyout;
  logic [1:0]         Hresp;
  logic [NUM_SLV-1:0] Pselx;
  logic               Penable;
  logic               Pwrite;
  logic [ADDR_W-1:0]  Paddr;
  logic [DATA_W-1:0]  Pwdata;
  logic [DATA_W-1:0]  Prdata;
  logic               Pready;
  logic               Pslverr;
  modport master (
    output valid, Hwrite, Haddr, Hwdata, Hselx, Prdata, Pready, Pslverr,
    input  Hrdata, Hreadyout, Hresp, Pselx, Penable, Pwrite, Paddr, Pwdata
  );
  modport slave (
    input  valid, Hwrite, Haddr, Hwdata, Hselx, Prdata, Pready, Pslverr,
    output Hrdata, Hreadyout, Hresp, Pselx, Penable, Pwrite, Paddr, Pwdata
  );
endinterface

// File: rtl/apb_bridge_fsm.sv
// apb_bridge_fsm: AHB-to-APB bridge; one APB transfer per request, ERROR on bad select, slave error or timeout
module apb_bridge_fsm #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input logic            HCLK,
  input logic            HRESETn,
  apb_bridge_fsm_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t             state, state_nx;
  logic [NUM_SLV-1:0] sel_q;
  logic [CW-1:0]      to_cnt;
  logic               sel_ok;
  logic               timed_out;
  assign sel_ok    = $onehot(bus.Hselx);
  assign timed_out = (TIMEOUT > 0) && !bus.Pready && (to_cnt == T_LAST);
  // state register; reset lands in IDLE so the state-decoded outputs drop at once
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= IDLE;
    else          state <= state_nx;
  // next state, plus every handshake output decoded from the registered state only
  always_comb begin
    state_nx      = state;
    bus.Hreadyout = (state == IDLE) || (state == ERR2);
    bus.Hresp     = {1'b0, (state == ERR1) || (state == ERR2)};
    bus.Pselx     = (state == SETUP || state == ACCESS) ? sel_q : '0;
    bus.Penable   = state == ACCESS;
    case (state)
      IDLE:    if (bus.valid) state_nx = !sel_ok ? ERR1 : bus.Hwrite ? WDATA : SETUP;
      WDATA:   state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  state_nx = bus.Pready ? (bus.Pslverr ? ERR1 : IDLE) : timed_out ? ERR1 : ACCESS;
      ERR1:    state_nx = ERR2;
      default: state_nx = IDLE;
    endcase
  end
  // request latch, write-data capture, read-data return and wait-state counter
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sel_q      <= '0;
      bus.Paddr  <= '0;
      bus.Pwrite <= 1'b0;
      bus.Pwdata <= '0;
      bus.Hrdata <= '0;
      to_cnt     <= '0;
    end else begin
      if (state == IDLE && bus.valid && sel_ok) begin
        sel_q      <= bus.Hselx;
        bus.Paddr  <= bus.Haddr;
        bus.Pwrite <= bus.Hwrite;
      end
      if (state == WDATA) bus.Pwdata <= bus.Hwdata;
      if (state == ACCESS && bus.Pready && !bus.Pslverr && !bus.Pwrite) bus.Hrdata <= bus.Prdata;
      to_cnt <= (state != ACCESS || TIMEOUT == 0) ? '0 :
                (!bus.Pready && to_cnt != '1) ? to_cnt + CW'(1) : to_cnt;
    end
endmodule

// File: tb/tb_apb_bridge_fsm.sv
// tb_apb_bridge_fsm: table-driven transfers scored through an expectation queue, plus reset corner cases
module tb_apb_bridge_fsm;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        slverr;
    int          lat;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          psel;
    int          pen;
  } vec_t;
  logic   HCLK;
  logic   HRESETn;
  int     checks;
  int     errors;
  bit     prev_err;
  vec_t   tv[10];
  vec_t   exp_q[$];
  apb_bridge_fsm_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();
  apb_bridge_fsm #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus)
  );
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to end earlier", $time);
    $fatal(1, "watchdog");
  end
  function automatic vec_t mk(logic wr, logic [31:0] addr, logic [3:0] sel, logic [31:0] wdata,
                              logic [31:0] prdata, int waits, logic slverr, int lat,
                              logic [1:0] resp, logic [31:0] rdata, int psel, int pen);
    vec_t v;
    v.wr = wr; v.addr = addr; v.sel = sel; v.wdata = wdata; v.prdata = prdata; v.waits = waits;
    v.slverr = slverr; v.lat = lat; v.resp = resp; v.rdata = rdata; v.psel = psel; v.pen = pen;
    return v;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int   n, nacc, ps, pe, bad, err1;
    bit   done;
    vec_t e;
    exp_q.push_back(v);
    bus.valid  = 1'b1;
    bus.Hwrite = v.wr;
    bus.Haddr  = v.addr;
    bus.Hselx  = v.sel;
    bus.Hwdata = v.wdata;
    if (prev_err) begin
      @(negedge HCLK);
      chk("idle_after_err", {bus.Hreadyout, bus.Hresp, bus.Pselx, bus.Penable}, {1'b1, 2'b00, 4'b0000, 1'b0});
    end
    n = 0; nacc = 0; ps = 0; pe = 0; bad = 0; err1 = 0; done = 0;
    while (!done && n < 40) begin
      @(negedge HCLK);
      n++;
      bus.valid = 1'b0;
      if (bus.Pselx != 0) begin
        ps++;
        if (bus.Pselx !== v.sel || bus.Paddr !== v.addr || bus.Pwrite !== v.wr || (v.wr && bus.Pwdata !== v.wdata)) bad++;
      end
      if (bus.Penable) begin
        pe++;
        nacc++;
      end
      if (!bus.Hreadyout && bus.Hresp == 2'b01) begin
        err1++;
        if (bus.Pselx != 0 || bus.Penable) bad++;
      end
      done = bus.Hreadyout;
      bus.Pready  = bus.Penable ? (nacc > v.waits) : 1'b1;
      bus.Pslverr = bus.Penable ? (v.slverr && nacc > v.waits) : 1'b1;
      bus.Prdata  = (bus.Penable && nacc > v.waits) ? v.prdata : $urandom;
    end
    e = exp_q.pop_front();
    chk("completed", {63'd0, done}, 64'd1);
    chk("latency", n, e.lat);
    chk("hresp", bus.Hresp, e.resp);
    chk("hrdata", bus.Hrdata, e.rdata);
    chk("psel_cycles", ps, e.psel);
    chk("penable_cycles", pe, e.pen);
    chk("err1_cycles", err1, {63'd0, e.resp[0]});
    chk("apb_stable", bad, 0);
    prev_err = e.resp[0];
  endtask
  initial begin
    checks = 0; errors = 0; prev_err = 0;
    tv[0] = mk(0, 32'h40,  4'b0010, 32'h0,        32'hDEADBEEF, 0,  0, 3, 2'b00, 32'hDEADBEEF, 2, 1);
    tv[1] = mk(1, 32'h100, 4'b0001, 32'h12345678, 32'h0,        2,  0, 6, 2'b00, 32'hDEADBEEF, 4, 3);
    tv[2] = mk(0, 32'h44,  4'b0100, 32'h0,        32'hCAFEF00D, 1,  0, 4, 2'b00, 32'hCAFEF00D, 3, 2);
    tv[3] = mk(0, 32'h48,  4'b1000, 32'h0,        32'h11111111, 0,  1, 4, 2'b01, 32'hCAFEF00D, 2, 1);
    tv[4] = mk(0, 32'h4C,  4'b0010, 32'h0,        32'h22222222, 10, 0, 7, 2'b01, 32'hCAFEF00D, 5, 4);
    tv[5] = mk(1, 32'h50,  4'b0000, 32'h33333333, 32'h0,        0,  0, 2, 2'b01, 32'hCAFEF00D, 0, 0);
    tv[6] = mk(0, 32'h54,  4'b0110, 32'h0,        32'h44444444, 0,  0, 2, 2'b01, 32'hCAFEF00D, 0, 0);
    tv[7] = mk(1, 32'h58,  4'b1000, 32'hA5A5A5A5, 32'h0,        0,  0, 4, 2'b00, 32'hCAFEF00D, 2, 1);
    tv[8] = mk(0, 32'h5C,  4'b0001, 32'h0,        32'h0BADC0DE, 3,  0, 6, 2'b00, 32'h0BADC0DE, 5, 4);
    tv[9] = mk(1, 32'h60,  4'b0100, 32'h5A5A5A5A, 32'h0,        1,  1, 6, 2'b01, 32'h0BADC0DE, 3, 2);
    HRESETn = 1'b0;
    bus.valid = 1'b0; bus.Hwrite = 1'b0; bus.Haddr = '0; bus.Hwdata = '0; bus.Hselx = '0;
    bus.Prdata = '0; bus.Pready = 1'b1; bus.Pslverr = 1'b1;
    #12;
    chk("rst_hreadyout", bus.Hreadyout, 1);
    chk("rst_hresp", bus.Hresp, 0);
    chk("rst_pselx", bus.Pselx, 0);
    chk("rst_penable", bus.Penable, 0);
    chk("rst_pwrite", bus.Pwrite, 0);
    chk("rst_paddr", bus.Paddr, 0);
    chk("rst_pwdata", bus.Pwdata, 0);
    chk("rst_hrdata", bus.Hrdata, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(tv[i]);
    if (prev_err) @(negedge HCLK);
    bus.valid = 1'b1; bus.Hwrite = 1'b0; bus.Haddr = 32'h80; bus.Hselx = 4'b0010;
    @(negedge HCLK);
    bus.valid = 1'b0;
    bus.Pready = 1'b0;
    @(negedge HCLK);
    chk("pre_rst_penable", bus.Penable, 1);
    chk("pre_rst_pselx", bus.Pselx, 4'b0010);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_pselx", bus.Pselx, 0);
    chk("async_rst_penable", bus.Penable, 0);
    chk("async_rst_hreadyout", bus.Hreadyout, 1);
    chk("async_rst_hresp", bus.Hresp, 0);
    chk("async_rst_paddr", bus.Paddr, 0);
    chk("async_rst_hrdata", bus.Hrdata, 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    prev_err = 0;
    run_vec(mk(0, 32'h70, 4'b0001, 32'h0, 32'h55AA55AA, 0, 0, 3, 2'b00, 32'h55AA55AA, 2, 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
